// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait freezes with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_memRd,
  input  logic [2:0]       exe_rd,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_en,
  output logic             id_exe_flush,
  output logic             exe_mem_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int unsigned     WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lu, freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_en    = 1'b0;
    id_exe_flush = 1'b0;
    exe_mem_en   = 1'b0;
    mem_wb_flush = 1'b0;

    lu = exe_memRd & ((id_uses_rs & (id_rs == exe_rd)) | (id_uses_rt & (id_rt == exe_rd)));
    freeze = ((state_q == ST_RUN) & mem_req & ~mem_ack)
           | ((state_q == ST_MEM_WAIT) & ~mem_ack)
           | (state_q == ST_ERR);

    // Priority: memory freeze, then branch squash (which also kills any load-use), then load-use.
    if (!rst) begin
      if (freeze) begin
        mem_wb_flush = 1'b1;
      end else if (br_taken) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        exe_mem_en   = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (lu) begin
        id_exe_en    = 1'b1;
        id_exe_flush = 1'b1;
        exe_mem_en   = 1'b1;
      end else begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        exe_mem_en   = 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_V)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase

    if (!pc_en && !rst && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!freeze && br_taken && !rst && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with CNT_W=2 shares the stimulus
// to exercise counter saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, exe_rd;
  logic        id_uses_rs, id_uses_rt, exe_memRd, br_taken, mem_req, mem_ack;

  logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_err;

  logic        pc_en2, if_id_en2, if_id_flush2, id_exe_en2, id_exe_flush2, exe_mem_en2, mem_wb_flush2;
  logic [1:0]  stall_cnt2, flush_cnt2;
  logic        mem_err2;

  logic [6:0]  ctl;
  int          n_total = 0;
  int          n_pass  = 0;

  // {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush, mem_wb_flush}
  localparam logic [6:0] CTL_NORM   = 7'b1111_000;
  localparam logic [6:0] CTL_BRANCH = 7'b1111_110;
  localparam logic [6:0] CTL_FREEZE = 7'b0000_001;
  localparam logic [6:0] CTL_RESET  = 7'b0000_000;

  assign ctl = {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush, mem_wb_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .exe_memRd(exe_memRd), .exe_rd(exe_rd), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_exe_en(id_exe_en), .id_exe_flush(id_exe_flush),
    .exe_mem_en(exe_mem_en), .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .exe_memRd(exe_memRd), .exe_rd(exe_rd), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en2), .if_id_en(if_id_en2),
    .if_id_flush(if_id_flush2), .id_exe_en(id_exe_en2), .id_exe_flush(id_exe_flush2),
    .exe_mem_en(exe_mem_en2), .mem_wb_flush(mem_wb_flush2), .stall_cnt(stall_cnt2),
    .flush_cnt(flush_cnt2), .mem_err(mem_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 3'd0; id_rt = 3'd0; exe_rd = 3'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; exe_memRd = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic set_lu();
    exe_memRd = 1'b1; exe_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_req = 1'b1;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(CTL_RESET));
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("run_normal_ctl", 32'(ctl), 32'(CTL_NORM));
    tick();
    chk("run_no_stall", 32'(stall_cnt), 32'd0);

    // Load-use on rs
    set_lu();
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_id_exe_flush", 32'(id_exe_flush), 32'd1);
    chk("lu_exe_mem_en", 32'(exe_mem_en), 32'd1);
    chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
    chk("lu_mem_wb_flush", 32'(mem_wb_flush), 32'd0);
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    exe_memRd = 1'b0;
    #1;
    chk("lu_gone_ctl", 32'(ctl), 32'(CTL_NORM));

    // uses_* flags gate the compare; register 0 is not special
    exe_memRd = 1'b1; exe_rd = 3'd5; id_rs = 3'd5; id_uses_rs = 1'b0;
    id_rt = 3'd2; id_uses_rt = 1'b1;
    #1;
    chk("lu_masked_ctl", 32'(ctl), 32'(CTL_NORM));
    id_rt = 3'd5;
    #1;
    chk("lu_rt_pc_en", 32'(pc_en), 32'd0);
    exe_rd = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1; id_rt = 3'd7;
    #1;
    chk("lu_r0_pc_en", 32'(pc_en), 32'd0);
    idle_inputs();
    tick();
    chk("lu_no_extra_stall", 32'(stall_cnt), 32'd1);

    // Branch with load-use hazard present: branch wins
    set_lu();
    br_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    idle_inputs();

    // Memory wait: 4 frozen cycles, freeze beats branch
    mem_req = 1'b1; br_taken = 1'b1;
    #1;
    chk("mw_freeze_run_ctl", 32'(ctl), 32'(CTL_FREEZE));
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_freeze_ctl", 32'(ctl), 32'(CTL_FREEZE));
      tick();
    end
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("mw_flush_cnt", 32'(flush_cnt), 32'd1);
    mem_ack = 1'b1; br_taken = 1'b1;
    #1;
    chk("mw_release_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    chk("mw_release_flush", 32'(flush_cnt), 32'd2);
    chk("mw_release_stall", 32'(stall_cnt), 32'd5);
    idle_inputs();
    #1;
    chk("mw_back_run_ctl", 32'(ctl), 32'(CTL_NORM));
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    chk("run_req_ack_ctl", 32'(ctl), 32'(CTL_NORM));
    tick();
    chk("run_req_ack_stall", 32'(stall_cnt), 32'd5);

    // Timeout: 1 RUN cycle + 15 MEM_WAIT cycles before ERR
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_err_not_yet", 32'(mem_err), 32'd0);
    chk("to_frozen_ctl", 32'(ctl), 32'(CTL_FREEZE));
    tick();
    chk("to_err_set", 32'(mem_err), 32'd1);
    mem_req = 1'b0; mem_ack = 1'b1;
    #1;
    chk("err_frozen_ctl", 32'(ctl), 32'(CTL_FREEZE));
    tick();
    tick();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_stall_cnt", 32'(stall_cnt), 32'd23);
    chk("sat_stall_cnt_a", 32'(stall_cnt2), 32'd3);
    chk("sat_flush_cnt_a", 32'(flush_cnt2), 32'd2);

    // Reset mid-MEM_WAIT
    rst = 1'b1;
    #1;
    chk("rst_err_clr", 32'(mem_err), 32'd0);
    tick();
    idle_inputs();
    rst = 1'b0;
    mem_req = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mw_stall_pre", 32'(stall_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", 32'(ctl), 32'(CTL_RESET));
    chk("rst_async_stall", 32'(stall_cnt), 32'd0);
    chk("rst_async_flush", 32'(flush_cnt), 32'd0);
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rst_release_ctl", 32'(ctl), 32'(CTL_NORM));
    tick();
    chk("rst_release_stall", 32'(stall_cnt), 32'd0);

    // Saturation with CNT_W=2
    set_lu();
    for (int i = 0; i < 3; i++) tick();
    chk("sat_stall_3", 32'(stall_cnt2), 32'd3);
    tick();
    tick();
    chk("sat_stall_hold", 32'(stall_cnt2), 32'd3);
    chk("wide_stall_5", 32'(stall_cnt), 32'd5);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
